axi_fifoin_lite_responder: RTL



---
 rtl/axi_fifoin_lite_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axi_fifoin_lite_responder.sv
// AXI4-Lite responder at the far end of the AXI_FIFOIN master port: DATA writes push a word FIFO,
// DATA reads pop it, and STATUS/CONTROL expose occupancy, sticky error flags and a flush.
module axi_fifoin_lite_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT,
  output logic                            FIFO_NOT_EMPTY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL_COUNT  = FIFO_DEPTH[CW-1:0];
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [1:0]    REG_DATA    = 2'd0;
  localparam logic [1:0]    REG_STATUS  = 2'd1;
  localparam logic [1:0]    REG_CONTROL = 2'd2;

  logic          ready_en;
  logic          aw_full, w_full;
  logic [1:0]    aw_sel_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  logic          aw_hs, w_hs, ar_hs, wr_exec;
  logic [1:0]    wr_sel, rd_sel;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          data_wr, push_req, push_ok, pop_req, pop_ok;
  logic          ctrl_wr, flush, clear_flags;
  logic [DW-1:0] rd_word;
  logic [1:0]    rd_resp;
  logic          unused_inputs;

  // Readies stay low through reset and while a response is outstanding, which caps each path at one transfer per two cycles.
  assign S_AXI_AWREADY = ready_en && !aw_full && !S_AXI_BVALID;
  assign S_AXI_WREADY  = ready_en && !w_full && !S_AXI_BVALID;
  assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign wr_exec = (aw_full || aw_hs) && (w_full || w_hs) && !S_AXI_BVALID;
  assign wr_sel  = aw_full ? aw_sel_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_full ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full ? w_strb_q : S_AXI_WSTRB;
  assign rd_sel  = S_AXI_ARADDR[3:2];

  assign data_wr     = wr_exec && (wr_sel == REG_DATA);
  assign push_req    = data_wr && (wr_strb == '1);
  assign pop_req     = ar_hs && (rd_sel == REG_DATA);
  assign pop_ok      = pop_req && (count != '0);
  assign push_ok     = push_req && ((count != FULL_COUNT) || pop_ok);
  assign ctrl_wr     = wr_exec && (wr_sel == REG_CONTROL);
  assign flush       = ctrl_wr && wr_data[0];
  assign clear_flags = ctrl_wr && wr_data[1];

  assign FIFO_COUNT     = count;
  assign FIFO_NOT_EMPTY = (count != '0);

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      REG_DATA: begin
        if (count != '0) rd_word = mem[rd_ptr];
        else             rd_resp = RESP_SLVERR;
      end
      REG_STATUS: begin
        rd_word[CW-1:0] = count;
        rd_word[16]     = (count == '0);
        rd_word[17]     = (count == FULL_COUNT);
        rd_word[18]     = overflow;
        rd_word[19]     = underflow;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en     <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_sel_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      if (wr_exec) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full  <= 1'b1;
          aw_sel_q <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end

      if (wr_exec) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (data_wr && !push_ok) ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end

      // A flush overrides any same-cycle pop; the popped word was already taken from the old head.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end

      overflow  <= (overflow && !clear_flags) || (push_req && !push_ok);
      underflow <= (underflow && !clear_flags) || (pop_req && !pop_ok);
    end
  end

endmodule
